branch_trace_driver: RTL and testbench
======================================

Name: branch_trace_driver

Overview:
Stimulus and scoring engine for the branch predictor interface; it sits on the other side of the predictor's input_ip/input_taken/output_prediction ports.
- A trace of (ip, taken) pairs is loaded into an internal memory.
- On start, it drives one branch IP per cycle and returns each branch's real outcome one cycle later.
- It compares the predictor's output against the real outcomes and counts hits and misses, for accuracy measurement in the lab harness.

Parameters:
DEPTH, 1024, trace memory entries
ADDR_BIT, 10, log2(DEPTH)
PRED_LAT, 2, cycles from an IP being driven to its prediction being valid on output_prediction
CNT_BIT, 32, width of the statistics counters

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  write one trace entry this cycle
load_ip  input  64  branch instruction address of entry
load_taken  input  1  actual outcome of entry
start  input  1  single-cycle pulse: begin replay of loaded trace
busy  output  1  replay or drain in progress
done  output  1  high from end of drain until next start/reset
input_ip  output  64  IP driven to the predictor
input_taken  output  1  outcome of the IP driven in the previous cycle
output_prediction  input  1  predictor's prediction, PRED_LAT cycles after its IP
trace_len  output  ADDR_BIT+1  number of entries loaded
total_count  output  CNT_BIT  predictions scored
hit_count  output  CNT_BIT  predictions equal to the outcome
miss_count  output  CNT_BIT  predictions not equal to the outcome

Behaviour:
- Reset (reset=1 at a rising edge): state IDLE; trace_len, all counters, busy, done, input_ip and input_taken go to 0. Memory contents are don't-care. Reset mid-RUN or mid-DRAIN aborts at once.
- States: IDLE, RUN, DRAIN, DONE.
- Loading, IDLE/DONE only:
  - load_valid writes mem[trace_len] and increments trace_len.
  - Writes are ignored when trace_len==DEPTH (saturates at DEPTH, no wrap).
  - load_valid is ignored in RUN/DRAIN.
- IDLE/DONE + start:
  - If trace_len==0: go straight to DONE; counters stay cleared.
  - Otherwise: clear counters, clear done, set rd_ptr=0, go to RUN.
  - start and load_valid in the same cycle: the load happens first, and start uses the incremented trace_len.
  - start is ignored while busy.
- RUN, cycle n (n=0..trace_len-1):
  - input_ip = mem[n].ip, registered so it is valid throughout cycle n.
  - input_taken = mem[n-1].taken; it is 0 in cycle 0.
  - After the last entry, go to DRAIN.
- DRAIN:
  - input_ip holds its last value.
  - In the first DRAIN cycle, input_taken = outcome of the last entry; afterwards it is 0.
  - Lasts PRED_LAT cycles, then DONE.
- busy=1 in RUN and DRAIN.
- Scoring:
  - Outcome bits go into a PRED_LAT-deep shift register alongside a valid bit.
  - In cycle n+PRED_LAT, output_prediction is compared with taken[n].
  - Each valid compare increments total_count, plus exactly one of hit_count/miss_count.
  - Counters saturate at all-ones.
  - At DONE, total_count == trace_len.
- done: set on the DRAIN→DONE transition; held until start or reset.
- Unused memory beyond trace_len is never read.

Test Plan:
1. Reset, load 4 entries ip=0x100/0x104/0x100/0x104 (all taken=1), start, with a model predictor returning a constant 1 -> trace_len=4; input_ip sequence 0x100,0x104,0x100,0x104 in cycles 0-3; input_taken 0,1,1,1,1 in cycles 0-4; done after 4+2 cycles; total=4, hit=4, miss=0.
2. Connect the real 2-bit predictor; 8 entries of ip=0x40, taken=1 -> first two predictions 0, then 1; miss=2, hit=6.
3. start with trace_len=0 -> DONE the next cycle; busy never high; all counters 0.
4. Load DEPTH+3 entries -> trace_len=DEPTH; entry 0 not overwritten; replay drives DEPTH IPs.
5. Assert reset in RUN cycle 3 of a 10-entry trace -> next cycle IDLE, busy=0, trace_len=0, counters 0.
6. start pulse during RUN, then a second start after done with the trace unchanged -> first pulse ignored; second run clears counters and reproduces identical totals.

Source files
------------

// File: rtl/branch_trace_driver.sv
// rtl/branch_trace_driver.sv - trace replay driver and hit/miss scorer for a branch predictor
module branch_trace_driver #(
   parameter int DEPTH    = 1024,
   parameter int ADDR_BIT = 10,
   parameter int PRED_LAT = 2,
   parameter int CNT_BIT  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_valid,
   input  logic [63:0]         load_ip,
   input  logic                load_taken,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [63:0]         input_ip,
   output logic                input_taken,
   input  logic                output_prediction,
   output logic [ADDR_BIT:0]   trace_len,
   output logic [CNT_BIT-1:0]  total_count,
   output logic [CNT_BIT-1:0]  hit_count,
   output logic [CNT_BIT-1:0]  miss_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam int DW = $clog2(PRED_LAT + 1);
   localparam logic [ADDR_BIT-1:0] ONE_A = 1;
   localparam logic [ADDR_BIT:0]   ONE_L = 1;
   localparam logic [ADDR_BIT:0]   FULL  = DEPTH[ADDR_BIT:0];

   logic [1:0]          state;
   logic [63:0]         mem_ip [DEPTH];
   logic                mem_taken [DEPTH];
   logic [ADDR_BIT-1:0] rd_ptr;
   logic                cur_valid, cur_taken;
   logic [PRED_LAT-1:0] pipe_valid, pipe_taken;
   logic [DW-1:0]       drain_cnt;

   logic                idle_like, do_load, do_start, last, score_en, hit;
   logic [ADDR_BIT:0]   len_next;
   logic [ADDR_BIT-1:0] nxt;
   logic [63:0]         first_ip;
   logic                first_taken;

   always_comb begin
      idle_like   = (state == S_IDLE) || (state == S_DONE);
      do_load     = idle_like && load_valid && (trace_len != FULL);
      do_start    = idle_like && start;
      len_next    = do_load ? trace_len + ONE_L : trace_len;
      // a same-cycle load into an empty trace must feed the first IP directly
      first_ip    = (do_load && trace_len == '0) ? load_ip : mem_ip[0];
      first_taken = (do_load && trace_len == '0) ? load_taken : mem_taken[0];
      nxt         = rd_ptr + ONE_A;
      last        = ({1'b0, rd_ptr} == trace_len - ONE_L);
      score_en    = pipe_valid[PRED_LAT-1];
      hit         = (output_prediction == pipe_taken[PRED_LAT-1]);
   end

   assign busy = (state == S_RUN) || (state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (do_load) begin
         mem_ip[trace_len[ADDR_BIT-1:0]]    <= load_ip;
         mem_taken[trace_len[ADDR_BIT-1:0]] <= load_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         trace_len   <= '0;
         total_count <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
         done        <= 1'b0;
         input_ip    <= '0;
         input_taken <= 1'b0;
         rd_ptr      <= '0;
         cur_valid   <= 1'b0;
         cur_taken   <= 1'b0;
         pipe_valid  <= '0;
         pipe_taken  <= '0;
         drain_cnt   <= '0;
      end else begin
         trace_len <= len_next;
         pipe_valid[0] <= cur_valid;
         pipe_taken[0] <= cur_taken;
         for (int k = 1; k < PRED_LAT; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_taken[k] <= pipe_taken[k-1];
         end
         if (score_en) begin
            if (total_count != '1) total_count <= total_count + CNT_BIT'(1);
            if (hit) begin
               if (hit_count != '1) hit_count <= hit_count + CNT_BIT'(1);
            end else begin
               if (miss_count != '1) miss_count <= miss_count + CNT_BIT'(1);
            end
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (do_start) begin
                  total_count <= '0;
                  hit_count   <= '0;
                  miss_count  <= '0;
                  if (len_next == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_RUN;
                     done        <= 1'b0;
                     rd_ptr      <= '0;
                     input_ip    <= first_ip;
                     input_taken <= 1'b0;
                     cur_taken   <= first_taken;
                     cur_valid   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               input_taken <= cur_taken;
               if (last) begin
                  state     <= S_DRAIN;
                  cur_valid <= 1'b0;
                  cur_taken <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  rd_ptr    <= nxt;
                  input_ip  <= mem_ip[nxt];
                  cur_taken <= mem_taken[nxt];
               end
            end
            default: begin
               input_taken <= cur_taken;
               if (drain_cnt == DW'(PRED_LAT - 1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_trace_driver.sv
// tb/tb_branch_trace_driver.sv - directed scoreboard bench for branch_trace_driver
module tb_branch_trace_driver;

   localparam int DEPTH    = 1024;
   localparam int ADDR_BIT = 10;
   localparam int PRED_LAT = 2;
   localparam int CNT_BIT  = 32;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                load_valid = 1'b0;
   logic [63:0]         load_ip = '0;
   logic                load_taken = 1'b0;
   logic                start = 1'b0;
   logic                busy, done, input_taken, output_prediction;
   logic [63:0]         input_ip;
   logic [ADDR_BIT:0]   trace_len;
   logic [CNT_BIT-1:0]  total_count, hit_count, miss_count;

   int errors = 0;
   int checks = 0;
   logic [63:0] q_ip[$];
   logic        q_tk[$];

   // model predictor: constant taken, or a 2-bit saturating counter table with two-cycle latency
   logic       pmode = 1'b0;
   logic [1:0] tbl [16];
   logic       p1, p2, busy_d;
   logic [3:0] idx_d;

   always #5 clk = ~clk;

   branch_trace_driver #(
      .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT), .PRED_LAT(PRED_LAT), .CNT_BIT(CNT_BIT)
   ) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ip(load_ip),
      .load_taken(load_taken), .start(start), .busy(busy), .done(done),
      .input_ip(input_ip), .input_taken(input_taken),
      .output_prediction(output_prediction), .trace_len(trace_len),
      .total_count(total_count), .hit_count(hit_count), .miss_count(miss_count)
   );

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) tbl[i] <= 2'b01;
         p1 <= 1'b0; p2 <= 1'b0; busy_d <= 1'b0; idx_d <= '0;
      end else begin
         p1     <= tbl[input_ip[5:2]][1];
         p2     <= p1;
         idx_d  <= input_ip[5:2];
         busy_d <= busy;
         if (busy_d) begin
            if (input_taken && tbl[idx_d] != 2'b11) tbl[idx_d] <= tbl[idx_d] + 2'b01;
            else if (!input_taken && tbl[idx_d] != 2'b00) tbl[idx_d] <= tbl[idx_d] - 2'b01;
         end
      end
   end

   assign output_prediction = pmode ? p2 : 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      q_ip.delete();
      q_tk.delete();
   endtask

   task automatic load(input logic [63:0] ip, input logic tk);
      load_valid = 1'b1; load_ip = ip; load_taken = tk;
      if (q_ip.size() < DEPTH) begin
         q_ip.push_back(ip);
         q_tk.push_back(tk);
      end
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   function automatic int ones();
      int n = 0;
      foreach (q_tk[i]) n += int'(q_tk[i]);
      return n;
   endfunction

   task automatic run(input int mid_start, input int exp_hit, input int exp_miss);
      logic [63:0] eip[$];
      logic        etk[$];
      logic [63:0] last_ip = '0;
      int          len, cyc;
      eip = q_ip;
      len = q_ip.size();
      etk.push_back(1'b0);
      foreach (q_tk[i]) etk.push_back(q_tk[i]);
      etk.push_back(1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < len + PRED_LAT + 20) begin
         start = (cyc == mid_start);
         if (eip.size() > 0) last_ip = eip.pop_front();
         chk("input_ip", input_ip, last_ip);
         if (etk.size() > 0) chk("input_taken", input_taken, etk.pop_front());
         else chk("input_taken_idle", input_taken, 0);
         chk("busy_run", busy, 1);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_latency", cyc, len + PRED_LAT);
      chk("done", done, 1);
      chk("busy_done", busy, 0);
      chk("total", total_count, len);
      chk("hit", hit_count, exp_hit);
      chk("miss", miss_count, exp_miss);
   endtask

   initial begin
      // 1: reset state, then a 4-entry trace against a constant-taken predictor
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_len", trace_len, 0);
      chk("rst_total", total_count, 0);
      chk("rst_hit", hit_count, 0);
      chk("rst_miss", miss_count, 0);
      chk("rst_ip", input_ip, 0);
      chk("rst_taken", input_taken, 0);
      load(64'h100, 1'b1); load(64'h104, 1'b1); load(64'h100, 1'b1); load(64'h104, 1'b1);
      chk("len4", trace_len, 4);
      run(-1, 4, 0);

      // 2: 2-bit counter predictor warms up over the first two predictions
      do_reset();
      pmode = 1'b1;
      for (int i = 0; i < 8; i++) load(64'h40, 1'b1);
      run(-1, 6, 2);
      pmode = 1'b0;

      // 5: reset in RUN cycle 3 aborts immediately
      do_reset();
      for (int i = 0; i < 10; i++) load(64'h200 + 64'(4 * i), i[0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("abort_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q_ip.delete(); q_tk.delete();
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_len", trace_len, 0);
      chk("abort_total", total_count, 0);
      chk("abort_hit", hit_count, 0);
      chk("abort_miss", miss_count, 0);

      // 3: start on an empty trace goes straight to DONE
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_total", total_count, 0);
      chk("empty_hit", hit_count, 0);
      chk("empty_miss", miss_count, 0);

      // 4: overfill saturates trace_len at DEPTH without overwriting entry 0
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) load(64'h1000 + 64'(8 * i), i[0]);
      chk("full_len", trace_len, DEPTH);
      run(-1, ones(), DEPTH - ones());

      // 6: start during RUN is ignored; a rerun reproduces identical totals
      do_reset();
      for (int i = 0; i < 6; i++) load(64'h300 + 64'(4 * i), (i % 3) == 0);
      run(2, ones(), 6 - ones());
      run(-1, ones(), 6 - ones());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
